// File: rtl/conv_stream_controller_pkg.sv
// conv_pkg: shared types and sizing helpers for the convolution stream
// controller.
//   conv_ctrl_state_t  sequencer states
//   pixels_per_frame() pixels in one square ImageWidth x ImageWidth frame
//   flush_len()        zeros needed after a frame so the sliding-window
//                      buffer can emit its final windows
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FEED  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } conv_ctrl_state_t;

    localparam int DEFAULT_IMAGE_WIDTH      = 4;
    localparam int DEFAULT_PIXELS_PER_FRAME = DEFAULT_IMAGE_WIDTH * DEFAULT_IMAGE_WIDTH;

    function automatic int pixels_per_frame(input int image_width);
        return image_width * image_width;
    endfunction

    // Enough zeros to push the last pixel to the centre of an N x N window:
    // (N-1)/2 full rows, (N-1)/2 columns, plus one to clock it out.
    function automatic int flush_len(input int image_width, input int n);
        return image_width * (n - 1) / 2 + (n - 1) / 2 + 1;
    endfunction

endpackage

// File: rtl/conv_stream_controller_addr_gen.sv
// conv_addr_gen: pixel index / channel bookkeeping and pixel memory address.
// Ports:
//   clk, res_n        clock, synchronous active-low reset
//   inc               advance to the next pixel of the current channel
//   clear             restart at channel 0, pixel 0
//   next_channel      advance to the next channel, pixel 0
//   mem_addr          channel*PixelsPerFrame + idx
//   channel           current channel index
//   last_pixel        idx is the final pixel of the frame
//   last_channel      channel is the final channel
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int PixelsPerFrame = DEFAULT_PIXELS_PER_FRAME,
    parameter int Channels       = 2,
    parameter int AddrW          = $clog2(Channels * PixelsPerFrame),
    parameter int ChanW          = $clog2(Channels) + 1
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             inc,
    input  logic             clear,
    input  logic             next_channel,
    output logic [AddrW-1:0] mem_addr,
    output logic [ChanW-1:0] channel,
    output logic             last_pixel,
    output logic             last_channel
);

    localparam int IdxW = (PixelsPerFrame > 1) ? $clog2(PixelsPerFrame) : 1;

    logic [IdxW-1:0]  idx_reg;
    logic [ChanW-1:0] channel_reg;

    always_ff @(posedge clk) begin
        if (!res_n) begin
            idx_reg     <= '0;
            channel_reg <= '0;
        end else if (clear) begin
            idx_reg     <= '0;
            channel_reg <= '0;
        end else if (next_channel) begin
            idx_reg     <= '0;
            channel_reg <= channel_reg + ChanW'(1);
        end else if (inc) begin
            // Wraps to 0 after the last pixel, which is harmless: the
            // controller leaves FEED on that same read.
            idx_reg <= idx_reg + IdxW'(1);
        end
    end

    assign mem_addr     = AddrW'(channel_reg) * AddrW'(PixelsPerFrame) + AddrW'(idx_reg);
    assign channel      = channel_reg;
    assign last_pixel   = (idx_reg == IdxW'(PixelsPerFrame - 1));
    assign last_channel = (channel_reg == ChanW'(Channels - 1));

endmodule

// File: rtl/conv_stream_controller.sv
// conv_stream_controller: sequencer feeding a sliding-window convolution
// buffer. On start it streams every channel's frame from pixel memory in
// raster order, appends the zero flush, waits for the buffer's done and
// moves on to the next channel.
// Optional build macro: CONV_STREAM_WATCHDOG_EN (DRAIN timeout -> sticky error).
// Ports:
//   clk, res_n                 clock, synchronous active-low reset
//   start                      begin processing (IDLE only)
//   ds_ready                   downstream may accept; low pauses reads/zeros
//   mem_rd_en, mem_addr        pixel memory read request
//   mem_rd_data                read data, one cycle after mem_rd_en
//   buf_in_valid, buf_in_data  pixel or flush zero into the buffer
//   buf_out_valid              buffer emitted a window
//   buf_out_done               buffer finished the current frame
//   busy                       not IDLE
//   channel                    current channel index
//   window_count               windows seen for the current channel (saturating)
//   frame_done                 one-cycle pulse after the last channel
//   error                      sticky watchdog flag (0 without the macro)
module conv_stream_controller
    import conv_pkg::*;
#(
    parameter int BitSize    = 4,
    parameter int N          = 3,
    parameter int ImageWidth = 4,
    parameter int Channels   = 2,
    parameter int AddrW      = $clog2(Channels * ImageWidth * ImageWidth)
) (
    input  logic                                      clk,
    input  logic                                      res_n,
    input  logic                                      start,
    input  logic                                      ds_ready,
    output logic                                      mem_rd_en,
    output logic [AddrW-1:0]                          mem_addr,
    input  logic [BitSize-1:0]                        mem_rd_data,
    output logic                                      buf_in_valid,
    output logic [BitSize-1:0]                        buf_in_data,
    input  logic                                      buf_out_valid,
    input  logic                                      buf_out_done,
    output logic                                      busy,
    output logic [$clog2(Channels):0]                 channel,
    output logic [$clog2(ImageWidth*ImageWidth)+1:0]  window_count,
    output logic                                      frame_done,
    output logic                                      error
);

    localparam int PixPerFrame = pixels_per_frame(ImageWidth);
    localparam int FlushLen    = flush_len(ImageWidth, N);
    localparam int FlushW      = $clog2(FlushLen + 1);
    localparam int ChanW       = $clog2(Channels) + 1;
    localparam int WinW        = $clog2(PixPerFrame) + 2;

    conv_ctrl_state_t   state_reg;
    logic [FlushW-1:0]  flush_cnt_reg;
    logic [WinW-1:0]    window_count_reg;
    logic               rd_pending_reg;

    logic issue_read;
    logic issue_zero;
    logic start_frame;
    logic drain_exit;
    logic advance_channel;
    logic wd_expire;
    logic last_pixel;
    logic last_channel;

    assign issue_read      = (state_reg == ST_FEED) && ds_ready;
    // A returning pixel owns the buffer input that cycle, so zeros wait.
    assign issue_zero      = (state_reg == ST_FLUSH) && ds_ready && !rd_pending_reg;
    assign start_frame     = (state_reg == ST_IDLE) && start;
    assign drain_exit      = (state_reg == ST_DRAIN) && (buf_out_done || wd_expire);
    assign advance_channel = drain_exit && !last_channel;

    conv_addr_gen #(
        .PixelsPerFrame (PixPerFrame),
        .Channels       (Channels),
        .AddrW          (AddrW),
        .ChanW          (ChanW)
    ) u_addr_gen (
        .clk          (clk),
        .res_n        (res_n),
        .inc          (issue_read),
        .clear        (start_frame),
        .next_channel (advance_channel),
        .mem_addr     (mem_addr),
        .channel      (channel),
        .last_pixel   (last_pixel),
        .last_channel (last_channel)
    );

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_reg        <= ST_IDLE;
            flush_cnt_reg    <= '0;
            window_count_reg <= '0;
            rd_pending_reg   <= 1'b0;
        end else begin
            rd_pending_reg <= issue_read;

            if ((state_reg != ST_IDLE) && buf_out_valid && !(&window_count_reg)) begin
                window_count_reg <= window_count_reg + WinW'(1);
            end

            // Clears below deliberately override the increment above.
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg        <= ST_FEED;
                        flush_cnt_reg    <= '0;
                        window_count_reg <= '0;
                    end
                end
                ST_FEED: begin
                    if (issue_read && last_pixel) begin
                        state_reg <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (issue_zero) begin
                        if (flush_cnt_reg == FlushW'(FlushLen - 1)) begin
                            flush_cnt_reg <= '0;
                            state_reg     <= ST_DRAIN;
                        end else begin
                            flush_cnt_reg <= flush_cnt_reg + FlushW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_exit) begin
                        if (last_channel) begin
                            state_reg <= ST_DONE;
                        end else begin
                            state_reg        <= ST_FEED;
                            window_count_reg <= '0;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CONV_STREAM_WATCHDOG_EN
    localparam int WdLimit = 2 * PixPerFrame;
    localparam int WdW     = $clog2(WdLimit);

    logic [WdW-1:0] wd_cnt_reg;
    logic           error_reg;

    // Fires on the WdLimit-th DRAIN cycle that has no done.
    assign wd_expire = (state_reg == ST_DRAIN) && !buf_out_done &&
                       (wd_cnt_reg == WdW'(WdLimit - 1));

    always_ff @(posedge clk) begin
        if (!res_n) begin
            wd_cnt_reg <= '0;
            error_reg  <= 1'b0;
        end else begin
            if (state_reg != ST_DRAIN) begin
                wd_cnt_reg <= '0;
            end else begin
                wd_cnt_reg <= wd_cnt_reg + WdW'(1);
            end
            if (wd_expire) begin
                error_reg <= 1'b1;
            end
        end
    end

    assign error = error_reg;
`else
    assign wd_expire = 1'b0;
    assign error     = 1'b0;
`endif

    assign mem_rd_en    = issue_read;
    assign buf_in_valid = rd_pending_reg || issue_zero;
    assign buf_in_data  = rd_pending_reg ? mem_rd_data : '0;
    assign busy         = (state_reg != ST_IDLE);
    assign frame_done   = (state_reg == ST_DONE);
    assign window_count = window_count_reg;

endmodule

// File: doc/conv_stream_controller.md
Name: conv_stream_controller

Overview:
- Sequencer in front of the sliding-window convolution buffer.
- On `start`, reads each channel's ImageWidth×ImageWidth frame from a pixel memory in raster order and streams it into the buffer.
- Then appends the zero flush the buffer needs to emit its final windows, and waits for the buffer's done.
- Loops over Channels and reports frame completion and per-channel window counts.

Parameters:
- BitSize, 4, pixel width in bits
- N, 3, convolution window size (odd)
- ImageWidth, 4, frame width = height in pixels
- Channels, 2, frames processed per `start`
- AddrW, $clog2(Channels*ImageWidth*ImageWidth), pixel memory address width

Ports:
- clk  in  1  clock
- res_n  in  1  synchronous active-low reset
- start  in  1  begin processing; sampled only in IDLE
- ds_ready  in  1  downstream may accept; low pauses issue of pixels and zeros
- mem_rd_en  out  1  pixel memory read strobe
- mem_addr  out  AddrW  read address = ch*ImageWidth*ImageWidth + idx
- mem_rd_data  in  BitSize  read data, valid one cycle after mem_rd_en
- buf_in_valid  out  1  pixel/zero valid into buffer
- buf_in_data  out  BitSize  pixel or zero into buffer
- buf_out_valid  in  1  buffer emitted a window this cycle
- buf_out_done  in  1  buffer finished the current frame
- busy  out  1  high in every state except IDLE
- channel  out  $clog2(Channels)+1  current channel index
- window_count  out  $clog2(ImageWidth*ImageWidth)+2  buf_out_valid count for the current channel
- frame_done  out  1  one-cycle pulse after the last channel drains
- error  out  1  sticky watchdog flag; see Optional Feature

Behaviour:
- Reset: clk and res_n only; synchronous, active-low.
  - Every output is 0 and the state is IDLE.
  - Reset mid-operation abandons the frame immediately; no pending read data is forwarded.
- FlushLen = ImageWidth*(N-1)/2 + (N-1)/2 + 1, which is 6 at the defaults.
- States: IDLE, FEED, FLUSH, DRAIN, DONE.
- IDLE:
  - start=1 → FEED with channel=0, idx=0, window_count=0.
  - start is ignored whenever busy=1.
- FEED:
  - Each cycle with ds_ready=1: mem_rd_en=1, mem_addr for idx, then idx++.
  - When ds_ready=0, no read is issued.
  - After the read for idx = ImageWidth²-1 is issued → FLUSH.
- Read return:
  - A registered rd_pending flag is set the cycle after any read.
  - buf_in_valid = rd_pending and buf_in_data = mem_rd_data, regardless of ds_ready.
  - Exactly one pixel enters the buffer per read.
- FLUSH:
  - Each cycle with ds_ready=1 and rd_pending=0: buf_in_valid=1, buf_in_data=0, and the flush counter increments.
  - After FlushLen zeros → DRAIN.
- DRAIN:
  - Waits for buf_out_done=1.
  - Then, if channel < Channels-1: channel++, idx=0, window_count=0 → FEED.
  - Otherwise → DONE.
- DONE: frame_done=1 for one cycle → IDLE. channel and window_count hold their last values until the next start.
- window_count increments on every buf_out_valid while busy and saturates at all-ones.
- buf_out_done outside DRAIN is ignored.
- buf_out_valid and buf_out_done arriving in the same cycle: the count updates first, then the transition uses the updated value.

Optional Feature:
- Macro: CONV_STREAM_WATCHDOG_EN.
- Defined:
  - DRAIN runs a cycle counter.
  - After 2*ImageWidth*ImageWidth cycles without buf_out_done: error=1 (sticky until reset), the channel is treated as done, and the normal DRAIN exit is taken.
- Undefined: DRAIN waits indefinitely, and error is tied to 0.

Decomposition:
- Package conv_pkg holds:
  - state enum conv_ctrl_state_t
  - function flush_len(ImageWidth, N)
  - localparam for pixels per frame
- One sub-module, conv_addr_gen, owns idx, channel and mem_addr generation, with inc/clear/next_channel controls and last_pixel/last_channel flags.
- The top module keeps the FSM, the flush counter and window_count.

Test Plan (defaults; start asserted at cycle 0):
- Single channel, ds_ready=1, memory holds 7,8,15,15 / 2,15,8,2 / 2,2,15,8 / 15,8,8,8 raster →
  - mem_rd_en cycles 1–16, addr 0–15
  - buf_in_valid cycles 2–17 with that data
  - zeros on cycles 18–23 (6)
  - DRAIN from cycle 24
- Two channels → second read burst uses addr 16–31; frame_done pulses exactly once, after the second buf_out_done; channel=1 at the end.
- ds_ready low for 3 cycles at idx=5 → addresses contiguous with no skips, the pixel sequence into the buffer is unchanged, total 16 pixels + 6 zeros.
- 9 buf_out_valid pulses before buf_out_done → window_count=9; it resets to 0 at the next channel.
- res_n low during FLUSH → next cycle all outputs 0 and IDLE; a new start replays from addr 0.
- CONV_STREAM_WATCHDOG_EN defined, buf_out_done never asserted → error=1 after 32 DRAIN cycles, then frame_done follows.
